// File: rtl/knn_sort_ctrl_if.sv
// knn_sort_ctrl_if: ready/valid result stream carrying
// one ranked sorter entry per transfer.
interface knn_sort_ctrl_if #(
  parameter int DW = 8
);
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [15:0]   res_idx;
  logic          res_last;

  modport master (
    output res_valid,
    output res_data,
    output res_idx,
    output res_last,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  res_idx,
    input  res_last,
    output res_ready
  );
endinterface

// File: rtl/knn_sort_ctrl.sv
// knn_sort_ctrl: sequences one kNN run through the
// distance/sort pipeline and streams the ranked results.
module knn_sort_ctrl #(
  parameter int W        = 32,
  parameter int HW_K     = 10,
  parameter int AW       = 16,
  parameter int PIPE_LAT = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW-1:0]       n_train,
  input  logic signed [W/2-1:0] test_x,
  input  logic signed [W/2-1:0] test_y,
  output logic                busy,
  output logic                done,
  output logic                mem_en,
  output logic [AW-1:0]       mem_addr,
  input  logic [W-1:0]        mem_data,
  output logic signed [W/2-1:0] px1,
  output logic signed [W/2-1:0] py1,
  output logic signed [W/2-1:0] px2,
  output logic signed [W/2-1:0] py2,
  output logic                srt_valid,
  output logic                srt_done,
  output logic [15:0]         srt_sel,
  input  logic [W/4-1:0]      srt_data,
  knn_sort_ctrl_if.master     rs
);

  localparam int CW = $clog2(PIPE_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    READ,
    FIN
  } state_t;

  state_t        state;
  logic [AW-1:0] n;
  logic [AW-1:0] rd;
  logic [15:0]   nres;
  logic          cap;
  logic [CW-1:0] cnt;

  // Run sequencer: load, drain, read-out and finish.
  // cap marks the cycle in which mem_data holds the
  // word for a read issued the cycle before.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_en       <= 1'b0;
      mem_addr     <= '0;
      px1          <= '0;
      py1          <= '0;
      px2          <= '0;
      py2          <= '0;
      srt_valid    <= 1'b0;
      srt_done     <= 1'b1;
      srt_sel      <= '0;
      rs.res_valid <= 1'b0;
      rs.res_data  <= '0;
      rs.res_idx   <= '0;
      rs.res_last  <= 1'b0;
      n            <= '0;
      rd           <= '0;
      nres         <= '0;
      cap          <= 1'b0;
      cnt          <= '0;
    end else begin
      cap <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            px1  <= test_x;
            py1  <= test_y;
            n    <= n_train;
            rd   <= '0;
            nres <= (32'(n_train) > HW_K) ?
                    16'(HW_K) : 16'(n_train);
            if (n_train == '0) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              srt_done <= 1'b0;
              mem_en   <= 1'b1;
              mem_addr <= '0;
              rd       <= AW'(1);
              state    <= LOAD;
            end
          end
        end
        LOAD: begin
          cap <= mem_en;
          if (rd != n) begin
            mem_en   <= 1'b1;
            mem_addr <= rd;
            rd       <= rd + AW'(1);
          end else begin
            mem_en <= 1'b0;
          end
          if (cap) begin
            px2 <= mem_data[W-1:W/2];
            py2 <= mem_data[W/2-1:0];
          end
          srt_valid <= cap;
          if (cap && !mem_en) state <= DRAIN;
        end
        DRAIN: begin
          if (srt_valid) begin
            srt_valid <= 1'b0;
            cnt       <= CW'(PIPE_LAT);
          end else begin
            srt_done <= 1'b1;
            if (cnt == '0) begin
              srt_sel <= '0;
              state   <= READ;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        READ: begin
          if (!rs.res_valid) begin
            rs.res_valid <= 1'b1;
            rs.res_data  <= srt_data;
            rs.res_idx   <= srt_sel;
            rs.res_last  <= (srt_sel == nres - 16'd1);
          end else if (rs.res_ready) begin
            rs.res_valid <= 1'b0;
            if (rs.res_last) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              srt_sel <= srt_sel + 16'd1;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_sort_ctrl.sv
// tb_knn_sort_ctrl: drives knn_sort_ctrl with a memory and
// sorter model, checks runs against a sorted-distance model.
module tb_knn_sort_ctrl;
  localparam int W        = 32;
  localparam int HW_K     = 10;
  localparam int AW       = 16;
  localparam int PIPE_LAT = 5;
  localparam int HW       = W / 2;
  localparam int DW       = W / 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [AW-1:0]        n_train = '0;
  logic signed [HW-1:0] test_x = '0;
  logic signed [HW-1:0] test_y = '0;
  logic                 busy, done, mem_en;
  logic                 srt_valid, srt_done;
  logic [AW-1:0]        mem_addr;
  logic [W-1:0]         mem_data;
  logic signed [HW-1:0] px1, py1, px2, py2;
  logic [15:0]          srt_sel;
  logic [DW-1:0]        srt_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  knn_sort_ctrl_if #(.DW(DW)) rs_if ();

  knn_sort_ctrl #(
    .W(W), .HW_K(HW_K), .AW(AW), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .n_train(n_train),
    .test_x(test_x),
    .test_y(test_y),
    .busy(busy),
    .done(done),
    .mem_en(mem_en),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .px1(px1),
    .py1(py1),
    .px2(px2),
    .py2(py2),
    .srt_valid(srt_valid),
    .srt_done(srt_done),
    .srt_sel(srt_sel),
    .srt_data(srt_data),
    .rs(rs_if)
  );

  // synchronous-read training memory
  logic [W-1:0] mem [64];
  logic [W-1:0] mem_q = '0;
  always @(posedge clk) if (mem_en) mem_q <= mem[mem_addr[5:0]];
  assign mem_data = mem_q;

  // sorter model: keeps the HW_K smallest squared distances
  logic [DW-1:0] sarr [HW_K];
  int  scnt = 0;
  logic sd_q = 1'b1;
  always @(posedge clk) begin
    int dx, dy, d, p;
    sd_q <= srt_done;
    if (sd_q && !srt_done) begin
      scnt = 0;
    end else if (srt_valid) begin
      dx = int'(px2) - int'(px1);
      dy = int'(py2) - int'(py1);
      d  = dx * dx + dy * dy;
      if (scnt < HW_K || d < int'(sarr[HW_K-1])) begin
        p = (scnt < HW_K) ? scnt : HW_K - 1;
        while (p > 0 && int'(sarr[p-1]) > d) begin
          sarr[p] = sarr[p-1];
          p--;
        end
        sarr[p] = DW'(d);
        if (scnt < HW_K) scnt++;
      end
    end
  end

  always_comb begin
    srt_data = '0;
    if (int'(srt_sel) < HW_K) srt_data = sarr[srt_sel];
  end

  // result-ready driver: 0 always, 1 random, 2 stall idx 2
  int rdy_mode = 0;
  int st_n = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_mode != 2) st_n = 0;
    if (rdy_mode == 0) begin
      rs_if.res_ready = 1'b1;
    end else if (rdy_mode == 1) begin
      rs_if.res_ready = ($urandom_range(0, 2) != 0);
    end else if (rs_if.res_valid && rs_if.res_idx == 16'd2
                 && st_n < 7) begin
      rs_if.res_ready = 1'b0;
      st_n++;
    end else begin
      rs_if.res_ready = 1'b1;
    end
  end

  // monitor
  logic mon_clr = 1'b0;
  int cyc = 0;
  int n_mem, n_sv, sv_first, sv_last, sd_bad, sd_low;
  int n_done, done_cyc, st_cyc, n_resv, first_res;
  int hold_bad, stall2;
  int addr_q[$];
  int rd_q[$];
  int ri_q[$];
  int rl_q[$];
  logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [DW-1:0] pd = '0;
  logic [15:0] pi = '0;

  always @(negedge clk) begin
    cyc++;
    if (mon_clr) begin
      n_mem = 0; n_sv = 0; sv_first = 0; sv_last = 0;
      sd_bad = 0; sd_low = 0; n_done = 0; done_cyc = 0;
      st_cyc = 0; n_resv = 0; first_res = 0;
      hold_bad = 0; stall2 = 0;
      addr_q.delete(); rd_q.delete();
      ri_q.delete(); rl_q.delete();
      pv = 1'b0;
    end else begin
      if (mem_en) begin
        n_mem++;
        addr_q.push_back(int'(mem_addr));
      end
      if (srt_valid) begin
        if (n_sv == 0) sv_first = cyc;
        sv_last = cyc;
        n_sv++;
        if (srt_done) sd_bad++;
      end
      if (!srt_done) sd_low++;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (start && !busy) st_cyc = cyc;
      if (rs_if.res_valid) begin
        if (n_resv == 0) begin
          first_res = cyc;
          if (!srt_done) sd_bad++;
        end
        n_resv++;
      end
      if (pv && !pr) begin
        if (!rs_if.res_valid || rs_if.res_data !== pd ||
            rs_if.res_idx !== pi || rs_if.res_last !== pl)
          hold_bad++;
        if (pi == 16'd2) stall2++;
      end
      if (rs_if.res_valid && rs_if.res_ready) begin
        rd_q.push_back(int'(rs_if.res_data));
        ri_q.push_back(int'(rs_if.res_idx));
        rl_q.push_back(int'(rs_if.res_last));
      end
      pv = rs_if.res_valid;
      pr = rs_if.res_ready;
      pd = rs_if.res_data;
      pi = rs_if.res_idx;
      pl = rs_if.res_last;
    end
  end

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pt(input int x, input int y);
    return {HW'(x), HW'(y)};
  endfunction

  function automatic logic [W-1:0] rnd_pt();
    return pt(int'($urandom_range(0, 10)) - 5,
              int'($urandom_range(0, 10)) - 5);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, ":ctl"},
        {busy, done, mem_en, srt_valid, srt_done,
         rs_if.res_valid, rs_if.res_last}, 7'b0000100);
    chk({tag, ":addr"}, mem_addr, 0);
    chk({tag, ":pts"}, {px1, py1, px2, py2}, 0);
    chk({tag, ":sel"}, srt_sel, 0);
    chk({tag, ":res"}, {rs_if.res_data, rs_if.res_idx}, 0);
  endtask

  task automatic check_run(input int n, input int tx,
                           input int ty, input string tag);
    int dq[$];
    int nres, aerr;
    logic signed [HW-1:0] sx, sy;
    for (int a = 0; a < n; a++) begin
      sx = mem[a][W-1:HW];
      sy = mem[a][HW-1:0];
      dq.push_back((int'(sx) - tx) * (int'(sx) - tx) +
                   (int'(sy) - ty) * (int'(sy) - ty));
    end
    dq.sort();
    nres = (n < HW_K) ? n : HW_K;
    chk({tag, ":mem_reads"}, n_mem, n);
    aerr = 0;
    foreach (addr_q[k]) if (addr_q[k] != k) aerr++;
    chk({tag, ":addr_seq"}, aerr, 0);
    chk({tag, ":valid_cnt"}, n_sv, n);
    if (n > 0) begin
      chk({tag, ":contig"}, sv_last - sv_first + 1, n);
      chk({tag, ":pipe_lat"},
          longint'((first_res - sv_last) >= PIPE_LAT), 1);
    end
    chk({tag, ":srt_done"}, sd_bad, 0);
    chk({tag, ":res_cnt"}, rd_q.size(), nres);
    for (int k = 0; k < nres && k < rd_q.size(); k++) begin
      chk($sformatf("%s:data%0d", tag, k), rd_q[k], dq[k]);
      chk($sformatf("%s:idx%0d", tag, k), ri_q[k], k);
      chk($sformatf("%s:last%0d", tag, k), rl_q[k],
          longint'(k == nres - 1));
    end
    chk({tag, ":hold"}, hold_bad, 0);
    chk({tag, ":done_cnt"}, n_done, 1);
  endtask

  task automatic run(input int n, input int tx, input int ty,
                     input int mode, input bit poke_busy,
                     input bit poke_fin, input string tag);
    bit got;
    got = 1'b0;
    rdy_mode = mode;
    @(posedge clk); #1;
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    n_train = AW'(n);
    test_x = HW'(tx);
    test_y = HW'(ty);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_train = AW'($urandom_range(1, 30));
    test_x = HW'(int'($urandom_range(0, 4)) - 2);
    test_y = HW'(int'($urandom_range(0, 4)) - 2);
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (poke_busy && k == 3) begin
        start = 1'b1;
        n_train = AW'(2);
        test_x = HW'(4);
      end
      if (poke_busy && k == 4) start = 1'b0;
      if (done) begin
        got = 1'b1;
        chk({tag, ":busy_fin"}, busy, 1);
        if (poke_fin) begin
          start = 1'b1;
          n_train = AW'(3);
        end
        break;
      end
    end
    chk({tag, ":done_seen"}, got, 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, ":busy_off"}, busy, 0);
    repeat (4) @(negedge clk);
    chk({tag, ":still_idle"}, busy, 0);
    check_run(n, tx, ty, tag);
  endtask

  initial begin
    bit got;
    int sv_snap, n;
    rs_if.res_ready = 1'b1;
    for (int a = 0; a < 64; a++) mem[a] = rnd_pt();

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_srt_done", srt_done, 1);

    // reference example from the distance table
    mem[0] = pt(3, 4);
    mem[1] = pt(1, 1);
    mem[2] = pt(-2, 0);
    mem[3] = pt(0, 5);
    run(4, 0, 0, 0, 1'b0, 1'b0, "ex4");

    for (int a = 0; a < 64; a++) mem[a] = rnd_pt();
    run(15, 1, -2, 0, 1'b0, 1'b0, "n15");

    run(6, -1, 2, 2, 1'b0, 1'b0, "bp");
    chk("bp:stall_cycles", stall2, 7);

    run(0, 2, 2, 0, 1'b0, 1'b0, "n0");
    chk("n0:done_lat", done_cyc - st_cyc, 1);
    chk("n0:srt_done_low", sd_low, 0);
    chk("n0:res_valid", n_resv, 0);

    for (int a = 0; a < 64; a++) mem[a] = rnd_pt();
    run(8, 2, -1, 1, 1'b1, 1'b1, "poke");

    // reset while loading
    for (int a = 0; a < 64; a++) mem[a] = rnd_pt();
    rdy_mode = 0;
    @(posedge clk); #1;
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    n_train = AW'(20);
    test_x = HW'(1);
    test_y = HW'(-1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (mem_en && mem_addr == AW'(7)) begin
        got = 1'b1;
        break;
      end
    end
    chk("midrst:reach7", got, 1);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    sv_snap = n_sv;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst:no_valid", n_sv, sv_snap);
    chk("midrst:no_done", n_done, 0);
    chk("midrst:idle", busy, 0);
    run(5, 0, 1, 0, 1'b0, 1'b0, "after_rst");

    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 64; a++) mem[a] = rnd_pt();
      n = int'($urandom_range(1, 20));
      run(n, int'($urandom_range(0, 4)) - 2,
          int'($urandom_range(0, 4)) - 2, 1, 1'b0, 1'b0,
          $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
